// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch/MDU stalls, memory-busy freeze, control flush.
// Define HAZARD_CTRL_MDU_EN to build the multiply/divide occupancy counter and MD hazard.
module hazard_ctrl #(
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [4:0]  i_ID_data_RSAddr,
   input  logic [4:0]  i_ID_data_RTAddr,
   input  logic        i_ID_ctrl_UseRS,
   input  logic        i_ID_ctrl_UseRT,
   input  logic        i_ID_ctrl_Branch,
   input  logic        i_ID_ctrl_PCSrc,
   input  logic        i_ID_ctrl_UseMD,
   input  logic        i_EX_ctrl_MemRead,
   input  logic        i_EX_ctrl_RegWrite,
   input  logic [4:0]  i_EX_data_WAddr,
   input  logic        i_MEM_ctrl_MemRead,
   input  logic [4:0]  i_MEM_data_WAddr,
   input  logic        i_EX_ctrl_MDStart,
   input  logic        i_MEM_ctrl_MemBusy,
   output logic        o_IF_ctrl_PCWrite,
   output logic        o_ID_ctrl_IFIDWrite,
   output logic        o_ID_ctrl_IFIDFlush,
   output logic        o_EX_ctrl_IDEXFlush,
   output logic        o_PIPE_ctrl_Freeze,
   output logic        o_EX_ctrl_MDBusy,
   output logic [1:0]  o_HZ_stat_State,
   output logic [15:0] o_HZ_stat_StallCnt
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned SC_W  = 16;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MDWAIT     = 2'd1,
      MEMWAIT    = 2'd2,
      MEMWAIT_MD = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              md_busy;
   logic              md_busy_nxt;
   logic              md_haz;
   logic              lu_haz;
   logic              br_haz;
   logic [SC_W-1:0]   stall_cnt;

   // Load in EX feeding a source operand of the ID instruction.
   assign lu_haz = i_EX_ctrl_MemRead && (i_EX_data_WAddr != 5'd0) &&
                   ((i_ID_ctrl_UseRS && (i_ID_data_RSAddr == i_EX_data_WAddr)) ||
                    (i_ID_ctrl_UseRT && (i_ID_data_RTAddr == i_EX_data_WAddr)));

   // Branch compares in ID, so any result not yet forwardable to ID stalls it.
   assign br_haz = i_ID_ctrl_Branch &&
                   ((i_EX_ctrl_RegWrite && (i_EX_data_WAddr != 5'd0) &&
                     ((i_ID_data_RSAddr == i_EX_data_WAddr) || (i_ID_data_RTAddr == i_EX_data_WAddr))) ||
                    (i_MEM_ctrl_MemRead && (i_MEM_data_WAddr != 5'd0) &&
                     ((i_ID_data_RSAddr == i_MEM_data_WAddr) || (i_ID_data_RTAddr == i_MEM_data_WAddr))));

`ifdef HAZARD_CTRL_MDU_EN
   logic [CNT_W-1:0] md_cnt;
   logic [CNT_W-1:0] md_cnt_nxt;
   logic             md_start;

   assign md_busy  = (state == MDWAIT) || (state == MEMWAIT_MD);
   assign md_haz   = i_ID_ctrl_UseMD && md_busy;
   assign md_start = i_EX_ctrl_MDStart && !md_busy && !i_MEM_ctrl_MemBusy;

   // Occupancy countdown; busy lasts through the cycle the counter reads zero.
   always_comb begin
      md_cnt_nxt  = md_cnt;
      md_busy_nxt = md_busy;
      if (md_start) begin
         md_cnt_nxt  = CNT_W'(MD_LATENCY - 1);
         md_busy_nxt = 1'b1;
      end else if (md_busy) begin
         if (md_cnt == '0) md_busy_nxt = 1'b0;
         else              md_cnt_nxt  = md_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) md_cnt <= '0;
      else       md_cnt <= md_cnt_nxt;
   end
`else
   logic unused_md;

   assign md_busy     = 1'b0;
   assign md_busy_nxt = 1'b0;
   assign md_haz      = 1'b0;
   assign unused_md   = &{1'b0, i_EX_ctrl_MDStart, i_ID_ctrl_UseMD, CNT_W'(MD_LATENCY)};
`endif

   // State tracks memory wait in bit 1 and MDU occupancy in bit 0.
   always_comb begin
      state_nxt = RUN;
      if (i_MEM_ctrl_MemBusy) state_nxt = md_busy_nxt ? MEMWAIT_MD : MEMWAIT;
      else                    state_nxt = md_busy_nxt ? MDWAIT : RUN;
   end

   // Pipeline controls: reset, then memory freeze, then data stall, then redirect flush.
   always_comb begin
      o_IF_ctrl_PCWrite   = 1'b1;
      o_ID_ctrl_IFIDWrite = 1'b1;
      o_ID_ctrl_IFIDFlush = 1'b0;
      o_EX_ctrl_IDEXFlush = 1'b0;
      o_PIPE_ctrl_Freeze  = 1'b0;
      if (!nrst) begin
         o_IF_ctrl_PCWrite   = 1'b0;
         o_ID_ctrl_IFIDWrite = 1'b0;
         o_ID_ctrl_IFIDFlush = 1'b1;
         o_EX_ctrl_IDEXFlush = 1'b1;
      end else if (i_MEM_ctrl_MemBusy) begin
         o_IF_ctrl_PCWrite   = 1'b0;
         o_ID_ctrl_IFIDWrite = 1'b0;
         o_PIPE_ctrl_Freeze  = 1'b1;
      end else if (lu_haz || br_haz || md_haz) begin
         o_IF_ctrl_PCWrite   = 1'b0;
         o_ID_ctrl_IFIDWrite = 1'b0;
         o_EX_ctrl_IDEXFlush = 1'b1;
      end else if (i_ID_ctrl_PCSrc) begin
         o_ID_ctrl_IFIDFlush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= RUN;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (!o_IF_ctrl_PCWrite && (stall_cnt != '1)) stall_cnt <= stall_cnt + SC_W'(1);
      end
   end

   assign o_EX_ctrl_MDBusy   = md_busy;
   assign o_HZ_stat_State    = state;
   assign o_HZ_stat_StallCnt = stall_cnt;

endmodule
